// File: rtl/game_countdown_timer.sv
// Game countdown timer: counts a loaded time limit down in whole game seconds.
// A prescaler divides clk into one-second decrements; pause/resume/abort are
// driven by the game-control FSM, remaining/time_up feed score and display.
//
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   load        pulse: remaining <= load_value, back to IDLE, partial second dropped
//   load_value  seconds to count down from
//   start       pulse: IDLE -> RUN (or straight to DONE when remaining is 0)
//   pause       level: hold the countdown while high (RUN/PAUSE only)
//   abort       pulse: RUN/PAUSE/DONE -> IDLE, remaining kept
//   remaining   seconds left
//   sec_tick    one-cycle pulse on each decrement
//   time_up     one-cycle pulse when the countdown reaches 0
//   done        high in DONE
//   running     high in RUN or PAUSE
//   warning     high in RUN/PAUSE while 0 < remaining <= WARN_SECS
module game_countdown_timer #(
    parameter int unsigned TICKS_PER_SEC = 100000000,
    parameter int unsigned TIME_W        = 5,
    parameter int unsigned WARN_SECS     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [TIME_W-1:0] load_value,
    input  logic              start,
    input  logic              pause,
    input  logic              abort,
    output logic [TIME_W-1:0] remaining,
    output logic              sec_tick,
    output logic              time_up,
    output logic              done,
    output logic              running,
    output logic              warning
);

    localparam int unsigned CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TIME_W-1:0] rem_q, rem_d;
    logic              sec_tick_q, sec_tick_d;
    logic              time_up_q, time_up_d;
    logic              done_q, done_d;
    logic              running_q, running_d;
    logic              warning_q, warning_d;
    logic              last_c;

    // Prescaler sits on the final cycle of the current game second
    assign last_c = (cnt_q == CNT_LAST);

    // Next-state, prescaler, countdown and output decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        sec_tick_d = 1'b0;
        time_up_d  = 1'b0;
        done_d     = 1'b0;
        running_d  = 1'b0;
        warning_d  = 1'b0;

        if (load) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            rem_d   = load_value;
        end else if (abort) begin
            if (state_q != ST_IDLE) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (rem_q != '0) begin
                            state_d = ST_RUN;
                            cnt_d   = '0;
                        end else begin
                            state_d   = ST_DONE;
                            time_up_d = 1'b1;
                        end
                    end
                end
                ST_RUN, ST_PAUSE: begin
                    // A second already on its last cycle in RUN completes even if pause rises
                    if (!pause || (state_q == ST_RUN && last_c)) begin
                        if (last_c) begin
                            cnt_d = '0;
                            if (rem_q != '0) begin
                                rem_d      = rem_q - TIME_W'(1);
                                sec_tick_d = 1'b1;
                            end
                            if (rem_q <= TIME_W'(1)) begin
                                state_d   = ST_DONE;
                                time_up_d = 1'b1;
                            end else begin
                                state_d = pause ? ST_PAUSE : ST_RUN;
                            end
                        end else begin
                            cnt_d   = cnt_q + CNT_W'(1);
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    rem_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Level outputs follow the state being entered so they line up with remaining
        done_d    = (state_d == ST_DONE);
        running_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
        warning_d = running_d && (rem_d != '0) && (32'(rem_d) <= 32'(WARN_SECS));
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            sec_tick_q <= 1'b0;
            time_up_q  <= 1'b0;
            done_q     <= 1'b0;
            running_q  <= 1'b0;
            warning_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            sec_tick_q <= sec_tick_d;
            time_up_q  <= time_up_d;
            done_q     <= done_d;
            running_q  <= running_d;
            warning_q  <= warning_d;
        end
    end

    assign remaining = rem_q;
    assign sec_tick  = sec_tick_q;
    assign time_up   = time_up_q;
    assign done      = done_q;
    assign running   = running_q;
    assign warning   = warning_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Testbench for game_countdown_timer: directed scenarios plus random stimulus,
// every cycle compared against a behavioural model of the countdown rules.
module tb_game_countdown_timer;

    localparam int unsigned TPS    = 4;
    localparam int unsigned TW     = 5;
    localparam int unsigned WARN   = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [TW-1:0] load_value = '0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          abort = 1'b0;
    logic [TW-1:0] remaining;
    logic          sec_tick, time_up, done, running, warning;

    int n_cmp = 0;
    int n_err = 0;

    // Model: what the timer is doing, how many clocks of the current second
    // have elapsed, and the seconds left
    int  m_mode;     // 0 stopped, 1 counting, 2 held, 3 finished
    int  m_elapsed;
    int  m_rem;
    bit  m_tick, m_tup;

    game_countdown_timer #(
        .TICKS_PER_SEC(TPS),
        .TIME_W       (TW),
        .WARN_SECS    (WARN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_value(load_value),
        .start     (start),
        .pause     (pause),
        .abort     (abort),
        .remaining (remaining),
        .sec_tick  (sec_tick),
        .time_up   (time_up),
        .done      (done),
        .running   (running),
        .warning   (warning)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock of the countdown rules applied to the sampled inputs
    task automatic model_step(input bit r, input bit ld, input int lv, input bit st,
                              input bit pa, input bit ab);
        m_tick = 0;
        m_tup  = 0;
        if (!r) begin
            m_mode = 0; m_elapsed = 0; m_rem = 0;
        end else if (ld) begin
            m_mode = 0; m_elapsed = 0; m_rem = lv;
        end else if (ab) begin
            if (m_mode != 0) begin m_mode = 0; m_elapsed = 0; end
        end else if (m_mode == 0) begin
            if (st) begin
                if (m_rem > 0) begin m_mode = 1; m_elapsed = 0; end
                else begin m_mode = 3; m_tup = 1; end
            end
        end else if (m_mode == 1 || m_mode == 2) begin
            if (!pa || (m_mode == 1 && m_elapsed == TPS - 1)) begin
                m_elapsed = m_elapsed + 1;
                m_mode = 1;
                if (m_elapsed == TPS) begin
                    m_elapsed = 0;
                    m_rem = m_rem - 1;
                    m_tick = 1;
                    if (m_rem == 0) begin m_mode = 3; m_tup = 1; end
                    else if (pa) m_mode = 2;
                end
            end else begin
                m_mode = 2;
            end
        end
    endtask

    // Drive one cycle, advance the model, sample #1 after the edge and compare
    task automatic cyc(input bit r, input bit ld, input int lv, input bit st,
                       input bit pa, input bit ab);
        bit act;
        rst_n = r; load = ld; load_value = TW'(lv); start = st; pause = pa; abort = ab;
        model_step(r, ld, lv, st, pa, ab);
        @(posedge clk);
        #1;
        act = (m_mode == 1 || m_mode == 2);
        check("remaining", 32'(remaining), 32'(m_rem));
        check("sec_tick",  32'(sec_tick),  32'(m_tick));
        check("time_up",   32'(time_up),   32'(m_tup));
        check("done",      32'(done),      32'(m_mode == 3));
        check("running",   32'(running),   32'(act));
        check("warning",   32'(warning),   32'(act && m_rem > 0 && m_rem <= WARN));
        rst_n = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
    endtask

    task automatic idle_cyc();
        cyc(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit pa_lvl;
        int p;
        m_mode = 0; m_elapsed = 0; m_rem = 0; m_tick = 0; m_tup = 0;

        // Reset
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("rst_remaining", 32'(remaining), 32'd0);
        check("rst_running", 32'(running), 32'd0);

        // Load 3, start: ticks at +5, +9, +13, time_up with the last
        cyc(1, 1, 3, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        for (int n = 2; n <= 16; n++) begin
            idle_cyc();
            check("s1_tick", 32'(sec_tick), 32'(n == 5 || n == 9 || n == 13));
            check("s1_time_up", 32'(time_up), 32'(n == 13));
            check("s1_done", 32'(done), 32'(n >= 13));
            if (n == 5)  check("s1_rem5",  32'(remaining), 32'd2);
            if (n == 9)  check("s1_rem9",  32'(remaining), 32'd1);
            if (n == 13) check("s1_rem13", 32'(remaining), 32'd0);
        end

        // Load 7: warning rises with the tick to 5, falls at 0
        cyc(1, 1, 7, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        check("s2_warn_start", 32'(warning), 32'd0);
        for (int n = 2; n <= 30; n++) begin
            idle_cyc();
            if (n == 5) check("s2_warn_rem6", 32'(warning), 32'd0);
            if (n == 9) begin
                check("s2_rem5", 32'(remaining), 32'd5);
                check("s2_warn_rem5", 32'(warning), 32'd1);
            end
            if (n == 29) begin
                check("s2_warn_end", 32'(warning), 32'd0);
                check("s2_done_end", 32'(done), 32'd1);
            end
        end

        // Load 2, pause 2 cycles into a second: the held partial second is kept
        cyc(1, 1, 2, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        idle_cyc();
        idle_cyc();
        for (int n = 0; n < 10; n++) begin
            cyc(1, 0, 0, 0, 1, 0);
            check("s3_pause_tick", 32'(sec_tick), 32'd0);
            check("s3_pause_rem", 32'(remaining), 32'd2);
        end
        for (int n = 1; n <= 3; n++) begin
            idle_cyc();
            check("s3_resume_tick", 32'(sec_tick), 32'(n == 2));
        end
        check("s3_rem_after", 32'(remaining), 32'd1);

        // Load 0, start: straight to DONE with a single time_up
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        check("s4_time_up", 32'(time_up), 32'd1);
        check("s4_done", 32'(done), 32'd1);
        idle_cyc();
        check("s4_time_up_once", 32'(time_up), 32'd0);
        check("s4_no_tick", 32'(sec_tick), 32'd0);

        // Load 4, abort mid-second at 3, restart: full second before next tick
        cyc(1, 1, 4, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        for (int n = 2; n <= 6; n++) idle_cyc();
        cyc(1, 0, 0, 0, 0, 1);
        check("s5_abort_running", 32'(running), 32'd0);
        check("s5_abort_rem", 32'(remaining), 32'd3);
        cyc(1, 0, 0, 1, 0, 0);
        for (int n = 2; n <= 6; n++) begin
            idle_cyc();
            check("s5_restart_tick", 32'(sec_tick), 32'(n == 5));
        end

        // Reset in the middle of a run
        cyc(1, 1, 5, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        idle_cyc();
        idle_cyc();
        cyc(0, 0, 0, 0, 0, 0);
        check("s6_rst_running", 32'(running), 32'd0);
        check("s6_rst_rem", 32'(remaining), 32'd0);

        // Load on the wrap cycle wins
        cyc(1, 1, 3, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        for (int n = 2; n <= 4; n++) idle_cyc();
        cyc(1, 1, 9, 0, 0, 0);
        check("s7_load_rem", 32'(remaining), 32'd9);
        check("s7_load_tick", 32'(sec_tick), 32'd0);
        check("s7_load_running", 32'(running), 32'd0);

        // Pause raised on the wrap cycle: decrement completes, then hold
        cyc(1, 1, 3, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        for (int n = 2; n <= 4; n++) idle_cyc();
        cyc(1, 0, 0, 0, 1, 0);
        check("s8_wrap_tick", 32'(sec_tick), 32'd1);
        check("s8_wrap_rem", 32'(remaining), 32'd2);
        cyc(1, 0, 0, 0, 1, 0);
        check("s8_held_running", 32'(running), 32'd1);
        check("s8_held_tick", 32'(sec_tick), 32'd0);

        // Random traffic against the model
        pa_lvl = 0;
        for (int n = 0; n < 3000; n++) begin
            p = int'($urandom_range(0, 999));
            if ($urandom_range(0, 9) == 0) pa_lvl = ~pa_lvl;
            cyc((p == 0) ? 1'b0 : 1'b1,
                (p >= 1 && p < 25),
                int'($urandom_range(0, 12)),
                (p >= 100 && p < 200),
                pa_lvl,
                (p >= 25 && p < 40));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
